// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory that is filled over a valid/ready stream, then serves fetches
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   pc            byte address from the fetch stage
//   instruction   word addressed by pc (combinational, zero outside RUN or past the loaded image)
//   load_valid    loader word present on load_data
//   load_data     program word to store
//   load_last     marks the final program word
//   load_ready    high while loading
//   cpu_run       program loaded, core may advance pc
//   fault         sticky illegal-fetch flag, held until reset
//   words_loaded  number of words written since reset
module instr_mem_loader #(
   parameter int DEPTH = 256,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc,
   output logic [31:0]      instruction,
   input  logic             load_valid,
   input  logic [31:0]      load_data,
   input  logic             load_last,
   output logic             load_ready,
   output logic             cpu_run,
   output logic             fault,
   output logic [CNT_W-1:0] words_loaded
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   wr_ptr;
   logic [31:0]     mem [DEPTH];
   logic [31:0]     word_idx;
   logic            accept;
   logic            illegal;
   logic            in_image;

   assign word_idx = {2'b00, pc[31:2]};
   assign accept   = (state == LOAD) && load_valid;
   assign illegal  = (pc[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));
   assign in_image = word_idx < 32'(words_loaded);

   always_comb begin
      state_n     = state;
      load_ready  = state == LOAD;
      cpu_run     = state == RUN;
      fault       = state == HALT;
      instruction = (state == RUN && !illegal && in_image) ? mem[pc[AW+1:2]] : 32'd0;
      if (state == LOAD && accept && (load_last || wr_ptr == AW'(DEPTH - 1)))
         state_n = RUN;
      else if (state == RUN && illegal)
         state_n = HALT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= LOAD;
         wr_ptr       <= '0;
         words_loaded <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            wr_ptr       <= wr_ptr + AW'(1);
            words_loaded <= words_loaded + CNT_W'(1);
         end
      end
   end

   // The array has no reset; stale words are hidden by the words_loaded bound.
   always_ff @(posedge clk) begin
      if (accept && !reset)
         mem[wr_ptr] <= load_data;
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
   localparam int DEPTH = 256;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      pc;
   logic [31:0]      instruction;
   logic             load_valid;
   logic [31:0]      load_data;
   logic             load_last;
   logic             load_ready;
   logic             cpu_run;
   logic             fault;
   logic [CNT_W-1:0] words_loaded;

   int checks = 0;
   int failures = 0;

   instr_mem_loader #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .cpu_run(cpu_run), .fault(fault),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
      pc = a;
      #1;
      check(tag, instruction, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_ready", 32'(load_ready), 32'd1);
      check("rst_run", 32'(cpu_run), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_wl", 32'(words_loaded), 32'd0);
      check("rst_instr", instruction, 32'd0);
   endtask

   initial begin
      reset = 1'b1; pc = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      step();
      do_reset();

      // basic load and fetch
      load_word(32'h11111111, 1'b0);
      load_word(32'h22222222, 1'b0);
      check("basic_run_early", 32'(cpu_run), 32'd0);
      check("basic_instr_load", instruction, 32'd0);
      load_word(32'h33333333, 1'b1);
      check("basic_run", 32'(cpu_run), 32'd1);
      check("basic_ready", 32'(load_ready), 32'd0);
      check("basic_wl", 32'(words_loaded), 32'd3);
      fetch("basic_pc0", 32'h0, 32'h11111111);
      fetch("basic_pc4", 32'h4, 32'h22222222);
      fetch("basic_pc8", 32'h8, 32'h33333333);
      fetch("basic_pcC", 32'hC, 32'h0);
      step();
      check("basic_nofault", 32'(fault), 32'd0);
      check("basic_still_run", 32'(cpu_run), 32'd1);

      // backpressure and idle gaps
      pc = '0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         load_valid = (i % 2) == 0;
         load_data  = load_valid ? 32'h10000000 + 32'(i / 2) : 32'hDEADBEEF;
         load_last  = load_valid && (i / 2) == 3;
         step();
      end
      load_valid = 1'b0; load_last = 1'b0;
      check("bp_wl", 32'(words_loaded), 32'd4);
      check("bp_run", 32'(cpu_run), 32'd1);
      load_valid = 1'b1; load_data = 32'hFFFFFFFF; load_last = 1'b1;
      step(); step(); step();
      load_valid = 1'b0; load_last = 1'b0;
      check("bp_wl_run", 32'(words_loaded), 32'd4);
      for (int i = 0; i < 4; i++)
         fetch("bp_fetch", 32'(4 * i), 32'h10000000 + 32'(i));

      // full array
      pc = '0;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("full_ready_last", 32'(load_ready), 32'd1);
         load_word(32'hA5000000 ^ 32'(i), 1'b0);
      end
      check("full_run", 32'(cpu_run), 32'd1);
      check("full_ready", 32'(load_ready), 32'd0);
      check("full_wl", 32'(words_loaded), 32'(DEPTH));
      fetch("full_last", 32'(4 * (DEPTH - 1)), 32'hA5000000 ^ 32'(DEPTH - 1));
      fetch("full_first", 32'h0, 32'hA5000000);

      // misaligned fetch
      fetch("mis_instr", 32'h2, 32'h0);
      check("mis_run_same", 32'(cpu_run), 32'd1);
      step();
      check("mis_fault", 32'(fault), 32'd1);
      check("mis_run", 32'(cpu_run), 32'd0);
      fetch("mis_pc0_instr", 32'h0, 32'h0);
      step();
      check("mis_sticky", 32'(fault), 32'd1);

      // out-of-range fetch
      do_reset();
      load_word(32'h00000005, 1'b1);
      fetch("oor_ok", 32'h0, 32'h00000005);
      fetch("oor_instr", 32'(4 * DEPTH), 32'h0);
      step();
      check("oor_fault", 32'(fault), 32'd1);
      check("oor_run", 32'(cpu_run), 32'd0);
      check("oor_ready", 32'(load_ready), 32'd0);

      // reset mid-load
      pc = '0;
      do_reset();
      load_word(32'h00000001, 1'b0);
      load_word(32'h00000002, 1'b0);
      reset = 1'b1; load_valid = 1'b1; load_data = 32'hBBBBBBBB;
      step();
      reset = 1'b0; load_valid = 1'b0;
      check("mid_wl0", 32'(words_loaded), 32'd0);
      check("mid_ready", 32'(load_ready), 32'd1);
      load_word(32'hAAAAAAAA, 1'b1);
      check("mid_wl1", 32'(words_loaded), 32'd1);
      fetch("mid_pc0", 32'h0, 32'hAAAAAAAA);
      fetch("mid_pc4_masked", 32'h4, 32'h0);

      // reset from HALT
      fetch("halt_instr", 32'h2, 32'h0);
      step();
      check("halt_fault", 32'(fault), 32'd1);
      pc = '0;
      do_reset();
      load_word(32'hCAFEF00D, 1'b1);
      check("halt_rerun", 32'(cpu_run), 32'd1);
      fetch("halt_reload", 32'h0, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction memory with a built-in program loader, sitting directly upstream of the instruction fetch stage. After reset it accepts program words over a valid/ready stream and writes them sequentially into an internal word array. It then releases the core by asserting `cpu_run`. In the run phase it returns the instruction word addressed by the fetch stage's `pc` combinationally, so the single-cycle core sees it in the same cycle. It flags illegal fetch addresses with a sticky fault that halts the core.

## Interface
- `DEPTH`, 256, number of 32-bit instruction words; power of two, ≥ 2.
- `CNT_W`, $clog2(DEPTH)+1, width of `words_loaded`.

- `clk`  input  1  main clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; sampled on rising edge of `clk`.
- `pc`  input  32  byte address from the fetch stage.
- `instruction`  output  32  instruction word for `pc`.
- `load_valid`  input  1  loader word present on `load_data`.
- `load_data`  input  32  program word to store.
- `load_last`  input  1  qualifies `load_valid`; marks the final program word.
- `load_ready`  output  1  block accepts a loader word this cycle.
- `cpu_run`  output  1  program loaded; the core may advance `pc`.
- `fault`  output  1  sticky illegal-fetch flag.
- `words_loaded`  output  CNT_W  number of words written since reset.

## Operation
- State machine with three states: LOAD, RUN, HALT. Reset enters LOAD.
- **LOAD state**
  - `load_ready` = 1.
  - A word is accepted on the edge where `load_valid` && `load_ready`.
  - Accepting a word writes `mem[wr_ptr] <= load_data`, increments `wr_ptr` and `words_loaded`.
  - LOAD→RUN on an accepted word with `load_last` = 1.
  - LOAD→RUN on an accepted word when `wr_ptr` == DEPTH-1 (array full), regardless of `load_last`.
  - `instruction` = 0 and `cpu_run` = 0 throughout LOAD.
- **RUN state**
  - `cpu_run` = 1 and `load_ready` = 0; loader inputs are ignored.
  - Word index is `pc[31:2]`.
  - If `pc[1:0]` != 0, or index ≥ DEPTH: `instruction` = 0, and at the next edge `fault` <= 1 and the state goes RUN→HALT.
  - Else if index ≥ `words_loaded`: `instruction` = 0, no fault (unloaded region reads as zero).
  - Else `instruction` = `mem[index]`, as a combinational (asynchronous) read.
- **HALT state**
  - `cpu_run` = 0, `fault` = 1, `instruction` = 0, `load_ready` = 0.
  - Only reset leaves HALT.
- **Memory contents**
  - The array is not cleared by reset.
  - Stale contents are masked by `words_loaded`: only indices below it are ever returned.
- `words_loaded` saturates at DEPTH. It never wraps, because LOAD exits when full.

## Timing
- Values after any reset edge:
  - state = LOAD, `wr_ptr` = 0, `words_loaded` = 0
  - `load_ready` = 1, `cpu_run` = 0, `fault` = 0, `instruction` = 0
- Reset has priority over all other inputs on the same edge. An accept on a reset edge is discarded.
- Reset mid-load or mid-run restarts loading at word 0 on the next cycle.
- `load_ready` is a function of state only. It does not depend on `load_valid`.
- A word accepted at edge N is counted in `words_loaded` from cycle N+1.
- `cpu_run` rises in the cycle after the accept of the last word. That word is readable in that same cycle.
- `instruction` has zero-cycle latency from `pc` in RUN: the read is combinational.
- `fault` and the drop of `cpu_run` appear one cycle after the illegal `pc` is presented. `instruction` is already 0 in the illegal cycle.
- A zero-length program is not possible: at least one word, carrying `load_last`, must be accepted to reach RUN.

## Test plan
- **Basic load and fetch**
  - Stimulus: reset; stream 0x11111111, 0x22222222, 0x33333333 with `load_last` on the third word.
  - Response: `cpu_run` = 1 one cycle after the third accept; `words_loaded` = 3.
  - Then pc = 0, 4, 8 → instruction = 0x11111111, 0x22222222, 0x33333333; pc = 0xC → 0, `fault` stays 0.
- **Backpressure and idle gaps**
  - Stimulus: `load_valid` toggled 1/0 across 4 words.
  - Response: only valid cycles write; `words_loaded` = 4.
  - Loader inputs driven during RUN do not change `words_loaded` or any memory content.
- **Full array**
  - Stimulus: DEPTH words with `load_last` = 0 throughout.
  - Response: RUN entered after word DEPTH-1; `load_ready` = 0.
  - Fetch at pc = 4·(DEPTH-1) returns the last word.
- **Misaligned and out-of-range fetch**
  - Stimulus: in RUN, pc = 0x2.
  - Response: `instruction` = 0 that cycle; next cycle `fault` = 1 and `cpu_run` = 0.
  - `fault` persists while pc returns to 0.
  - Repeat from a fresh reset with pc = 4·DEPTH: same result.
- **Reset mid-load**
  - Stimulus: load 2 words; assert reset while `load_valid` = 1; reload 1 word 0xAAAAAAAA with `load_last`.
  - Response: `words_loaded` = 1; pc = 0 → 0xAAAAAAAA.
  - pc = 4 → 0, because the stale word is masked.
- **Reset from HALT**
  - Stimulus: force a fault, then reset.
  - Response: `fault` = 0, `load_ready` = 1, `cpu_run` = 0; normal reload succeeds.
